alu_share_arbiter: RTL and testbench

//  Shares the single-cycle ALU between two requesters (req0, req1) with round-robin arbitration.
//  Per-requester valid/ready request channel; one shared response channel tagged with requester id.

---
 rtl/alu_share_arbiter.sv | 156 +++++++++++++++
 tb/tb_alu_share_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// alu_share_arbiter
//   Shares one single-cycle ALU between two requesters using round-robin
//   arbitration. Each requester has its own valid/ready request channel; a
//   single response channel returns the captured ALU result tagged with the
//   id of the requester that issued it.
//
//   Operation is a three-state FSM:
//     IDLE : pick a requester, accept its operands (combinational ready)
//     EXEC : hold the latched operands on the ALU inputs for ALU_LAT cycles
//     RESP : present result/zero/id until the consumer takes it
//
// Ports
//   clk_i, rst_i                 clock (rising edge), async reset (active-low)
//   reqN_valid_i / reqN_ready_o  request handshake, N = 0,1
//   reqN_src1_i/src2_i           operands
//   reqN_shamt_i, reqN_ctrl_i    shift amount and ALU control (not decoded)
//   alu_src1_o..alu_ctrl_o       latched operands driven to the ALU
//   alu_result_i, alu_zero_i     ALU outputs, captured at the end of EXEC
//   resp_valid_o / resp_ready_i  response handshake
//   resp_id_o, resp_result_o,
//   resp_zero_o                  captured response payload
//   busy_o                       high whenever the FSM is not IDLE
// -----------------------------------------------------------------------------
module alu_share_arbiter #(
  parameter int DATA_W  = 32,
  parameter int CTRL_W  = 4,
  parameter int SHAMT_W = 5,
  parameter int ALU_LAT = 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               req0_valid_i,
  output logic               req0_ready_o,
  input  logic [DATA_W-1:0]  req0_src1_i,
  input  logic [DATA_W-1:0]  req0_src2_i,
  input  logic [SHAMT_W-1:0] req0_shamt_i,
  input  logic [CTRL_W-1:0]  req0_ctrl_i,
  input  logic               req1_valid_i,
  output logic               req1_ready_o,
  input  logic [DATA_W-1:0]  req1_src1_i,
  input  logic [DATA_W-1:0]  req1_src2_i,
  input  logic [SHAMT_W-1:0] req1_shamt_i,
  input  logic [CTRL_W-1:0]  req1_ctrl_i,
  output logic [DATA_W-1:0]  alu_src1_o,
  output logic [DATA_W-1:0]  alu_src2_o,
  output logic [SHAMT_W-1:0] alu_shamt_o,
  output logic [CTRL_W-1:0]  alu_ctrl_o,
  input  logic [DATA_W-1:0]  alu_result_i,
  input  logic               alu_zero_i,
  output logic               resp_valid_o,
  input  logic               resp_ready_i,
  output logic               resp_id_o,
  output logic [DATA_W-1:0]  resp_result_o,
  output logic               resp_zero_o,
  output logic               busy_o
);

  // ALU_LAT-1 must fit in the counter; keep at least one bit for ALU_LAT=1.
  localparam int CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e             state_q;
  logic [DATA_W-1:0]  src1_q;
  logic [DATA_W-1:0]  src2_q;
  logic [SHAMT_W-1:0] shamt_q;
  logic [CTRL_W-1:0]  ctrl_q;
  logic [DATA_W-1:0]  result_q;
  logic               zero_q;
  logic               id_q;
  logic               last_grant_q;
  logic [CNT_W-1:0]   cnt_q;

  logic               gnt_vld;
  logic               gnt_id;
  logic               hs;

  // Round-robin: a lone requester always wins; on a tie the requester that
  // was not served last wins.
  always_comb begin
    gnt_vld = req0_valid_i | req1_valid_i;
    gnt_id  = 1'b0;
    if (req0_valid_i && req1_valid_i) begin
      gnt_id = ~last_grant_q;
    end else begin
      gnt_id = req1_valid_i;
    end
  end

  // Ready is gated by rst_i so that every output reads 0 while in reset,
  // even with a requester already asserting valid.
  assign hs           = rst_i && (state_q == IDLE) && gnt_vld;
  assign req0_ready_o = hs && !gnt_id;
  assign req1_ready_o = hs &&  gnt_id;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= IDLE;
      src1_q       <= '0;
      src2_q       <= '0;
      shamt_q      <= '0;
      ctrl_q       <= '0;
      result_q     <= '0;
      zero_q       <= 1'b0;
      id_q         <= 1'b0;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt_vld) begin
            src1_q       <= gnt_id ? req1_src1_i  : req0_src1_i;
            src2_q       <= gnt_id ? req1_src2_i  : req0_src2_i;
            shamt_q      <= gnt_id ? req1_shamt_i : req0_shamt_i;
            ctrl_q       <= gnt_id ? req1_ctrl_i  : req0_ctrl_i;
            id_q         <= gnt_id;
            last_grant_q <= gnt_id;
            cnt_q        <= CNT_W'(ALU_LAT - 1);
            state_q      <= EXEC;
          end
        end
        EXEC: begin
          if (cnt_q == '0) begin
            result_q <= alu_result_i;
            zero_q   <= alu_zero_i;
            state_q  <= RESP;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        RESP: begin
          if (resp_ready_i) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign alu_src1_o    = src1_q;
  assign alu_src2_o    = src2_q;
  assign alu_shamt_o   = shamt_q;
  assign alu_ctrl_o    = ctrl_q;
  assign resp_valid_o  = (state_q == RESP);
  assign resp_id_o     = id_q;
  assign resp_result_o = result_q;
  assign resp_zero_o   = zero_q;
  assign busy_o        = (state_q != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
module tb_alu_share_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- instance with ALU_LAT = 1 ----------------
  logic        v0, v1, r0, r1;
  logic [31:0] s1_0, s2_0, s1_1, s2_1;
  logic [4:0]  sh0, sh1;
  logic [3:0]  c0, c1;
  logic [31:0] a_src1, a_src2, a_res;
  logic [4:0]  a_sh;
  logic [3:0]  a_ctrl;
  logic        a_zero;
  logic        rsp_v, rsp_rdy, rsp_id, rsp_z, busy;
  logic [31:0] rsp_res;

  alu_share_arbiter #(.DATA_W(32), .CTRL_W(4), .SHAMT_W(5), .ALU_LAT(1)) u_dut (
    .clk_i(clk), .rst_i(rst_n),
    .req0_valid_i(v0), .req0_ready_o(r0), .req0_src1_i(s1_0), .req0_src2_i(s2_0),
    .req0_shamt_i(sh0), .req0_ctrl_i(c0),
    .req1_valid_i(v1), .req1_ready_o(r1), .req1_src1_i(s1_1), .req1_src2_i(s2_1),
    .req1_shamt_i(sh1), .req1_ctrl_i(c1),
    .alu_src1_o(a_src1), .alu_src2_o(a_src2), .alu_shamt_o(a_sh), .alu_ctrl_o(a_ctrl),
    .alu_result_i(a_res), .alu_zero_i(a_zero),
    .resp_valid_o(rsp_v), .resp_ready_i(rsp_rdy), .resp_id_o(rsp_id),
    .resp_result_o(rsp_res), .resp_zero_o(rsp_z), .busy_o(busy)
  );

  // ---------------- instance with ALU_LAT = 3 ----------------
  logic        x_v0, x_r0, x_r1;
  logic [31:0] x_s1, x_s2;
  logic [4:0]  x_sh;
  logic [3:0]  x_c;
  logic [31:0] x_a_src1, x_a_src2, x_a_res;
  logic [4:0]  x_a_sh;
  logic [3:0]  x_a_ctrl;
  logic        x_a_zero;
  logic        x_rsp_v, x_rsp_id, x_rsp_z, x_busy;
  logic [31:0] x_rsp_res;

  alu_share_arbiter #(.DATA_W(32), .CTRL_W(4), .SHAMT_W(5), .ALU_LAT(3)) u_dut3 (
    .clk_i(clk), .rst_i(rst_n),
    .req0_valid_i(x_v0), .req0_ready_o(x_r0), .req0_src1_i(x_s1), .req0_src2_i(x_s2),
    .req0_shamt_i(x_sh), .req0_ctrl_i(x_c),
    .req1_valid_i(1'b0), .req1_ready_o(x_r1), .req1_src1_i(32'd0), .req1_src2_i(32'd0),
    .req1_shamt_i(5'd0), .req1_ctrl_i(4'd0),
    .alu_src1_o(x_a_src1), .alu_src2_o(x_a_src2), .alu_shamt_o(x_a_sh), .alu_ctrl_o(x_a_ctrl),
    .alu_result_i(x_a_res), .alu_zero_i(x_a_zero),
    .resp_valid_o(x_rsp_v), .resp_ready_i(1'b1), .resp_id_o(x_rsp_id),
    .resp_result_o(x_rsp_res), .resp_zero_o(x_rsp_z), .busy_o(x_busy)
  );

  // Behavioural single-cycle ALU; unknown codes give result 0, zero 1.
  function automatic logic [32:0] alu_f(input logic [3:0] ctrl, input logic [31:0] a,
                                        input logic [31:0] b, input logic [4:0] sh);
    logic [31:0] r;
    case (ctrl)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: r = a + b;
      4'b0110: r = a - b;
      4'b1000: r = $signed(b) >>> sh;
      default: r = 32'd0;
    endcase
    return {(r == 32'd0), r};
  endfunction

  always_comb {a_zero, a_res} = alu_f(a_ctrl, a_src1, a_src2, a_sh);
  always_comb {x_a_zero, x_a_res} = alu_f(x_a_ctrl, x_a_src1, x_a_src2, x_a_sh);

  // Scoreboard entries: {id, zero, result}
  logic [33:0] exp_q[$];
  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_hs(input string tag, input int exp_who);
    int who = -1;
    for (int i = 0; i < 8 && who < 0; i++) begin
      @(negedge clk);
      if (r0 && v0) who = 0;
      else if (r1 && v1) who = 1;
    end
    chk({tag, "_grant"}, who, exp_who);
    chk({tag, "_onehot"}, {63'd0, r0 & r1}, 64'd0);
    @(posedge clk); #1;
    if (who == 0) v0 = 1'b0;
    else if (who == 1) v1 = 1'b0;
  endtask

  // Called right after a handshake; checks latency, payload, stall stability.
  task automatic wait_resp(input string tag, input int exp_lat, input int hold);
    int n = 0;
    logic [33:0] e;
    rsp_rdy = (hold == 0);
    for (int i = 1; i <= 10 && n == 0; i++) begin
      @(negedge clk);
      if (rsp_v) n = i;
    end
    chk({tag, "_lat"}, n, exp_lat);
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else e = '1;
    chk({tag, "_resp"}, {rsp_id, rsp_z, rsp_res}, e);
    chk({tag, "_rdy_in_resp"}, {r0, r1}, 2'b00);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({tag, "_hold"}, {rsp_v, busy, r0, r1, rsp_id, rsp_z, rsp_res}, {4'b1100, e});
    end
    rsp_rdy = 1'b1;
    @(posedge clk); #1;
    chk({tag, "_done"}, {rsp_v, busy}, 2'b00);
  endtask

  initial begin
    rst_n = 1'b0; rsp_rdy = 1'b1;
    v0 = 1'b1; v1 = 1'b0; s1_0 = 0; s2_0 = 0; sh0 = 0; c0 = 0;
    s1_1 = 0; s2_1 = 0; sh1 = 0; c1 = 0;
    x_v0 = 1'b0; x_s1 = 0; x_s2 = 0; x_sh = 0; x_c = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", {r0, r1, rsp_v, busy, rsp_id, rsp_z, rsp_res, a_src1, a_ctrl},
        '0);
    v0 = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: req0 ADD 5+7
    v0 = 1'b1; s1_0 = 5; s2_0 = 7; c0 = 4'b0010;
    exp_q.push_back({1'b0, 1'b0, 32'd12});
    wait_hs("t1", 0);
    s1_0 = 32'hDEAD; s2_0 = 32'hBEEF;  // post-handshake changes must be ignored
    chk("t1_alu_in", {busy, a_src1, a_src2, a_ctrl}, {1'b1, 32'd5, 32'd7, 4'b0010});
    wait_resp("t1", 2, 0);
    chk("t1_alu_hold", {a_src1, a_src2}, {32'd5, 32'd7});

    // fresh reset so the tie below depends on the reset value of last grant
    rst_n = 1'b0; #1;
    chk("rst2_outs", {rsp_v, busy, a_src1, a_src2, a_ctrl}, '0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // 3: tie after reset -> req0 (OR 3|4) then req1 (AND 6&3)
    v0 = 1'b1; s1_0 = 3; s2_0 = 4; c0 = 4'b0001;
    v1 = 1'b1; s1_1 = 6; s2_1 = 3; c1 = 4'b0000;
    exp_q.push_back({1'b0, 1'b0, 32'd7});
    exp_q.push_back({1'b1, 1'b0, 32'd2});
    wait_hs("t3a", 0);
    wait_resp("t3a", 2, 0);
    wait_hs("t3b", 1);
    wait_resp("t3b", 2, 0);
    // next tie must go back to req0
    v0 = 1'b1; s1_0 = 32'h100; s2_0 = 32'h23; c0 = 4'b0010;
    v1 = 1'b1; s1_1 = 32'h50; s2_1 = 32'h10; c1 = 4'b0110;
    exp_q.push_back({1'b0, 1'b0, 32'h123});
    exp_q.push_back({1'b1, 1'b0, 32'h40});
    wait_hs("t3c", 0);
    wait_resp("t3c", 2, 0);
    wait_hs("t3d", 1);
    wait_resp("t3d", 2, 0);

    // 2: req1 SUB 9-9 -> zero
    v1 = 1'b1; s1_1 = 9; s2_1 = 9; c1 = 4'b0110;
    exp_q.push_back({1'b1, 1'b1, 32'd0});
    wait_hs("t2", 1);
    chk("t2_r0", {63'd0, r0}, 64'd0);
    wait_resp("t2", 2, 0);

    // 4: consumer stalls 3 cycles while req1 waits
    v0 = 1'b1; s1_0 = 32'h10; s2_0 = 32'h20; c0 = 4'b0010;
    exp_q.push_back({1'b0, 1'b0, 32'h30});
    wait_hs("t4", 0);
    v1 = 1'b1; s1_1 = 32'hFF; s2_1 = 32'h0F; c1 = 4'b0000;
    exp_q.push_back({1'b1, 1'b0, 32'h0F});
    wait_resp("t4", 2, 3);
    wait_hs("t4b", 1);
    wait_resp("t4b", 2, 0);

    // 5: reset during EXEC drops the op
    v1 = 1'b1; s1_1 = 1; s2_1 = 2; c1 = 4'b0010;
    wait_hs("t5", 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_outs", {r0, r1, rsp_v, busy, rsp_id, rsp_z, rsp_res, a_src1, a_src2, a_sh, a_ctrl},
        '0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    v1 = 1'b1; s1_1 = 3; s2_1 = 4; c1 = 4'b0010;
    exp_q.push_back({1'b1, 1'b0, 32'd7});
    wait_hs("t5b", 1);
    wait_resp("t5b", 2, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t5_no_stale", {63'd0, rsp_v}, 64'd0);
    end
    chk("t5_q_empty", exp_q.size(), 0);

    // 6: ALU_LAT=3, SRA 0x80000000 >>> 4
    @(posedge clk); #1;
    x_v0 = 1'b1; x_s1 = 0; x_s2 = 32'h8000_0000; x_sh = 5'd4; x_c = 4'b1000;
    begin
      int seen = 0;
      for (int i = 0; i < 8 && seen == 0; i++) begin
        @(negedge clk);
        if (x_r0) seen = 1;
      end
      chk("t6_grant", seen, 1);
    end
    @(posedge clk); #1;
    x_v0 = 1'b0; x_s2 = 32'h1234_5678; x_sh = 5'd1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      chk("t6_exec", {x_rsp_v, x_busy, x_a_src2, x_a_sh, x_a_ctrl},
          {1'b0, 1'b1, 32'h8000_0000, 5'd4, 4'b1000});
    end
    @(negedge clk);
    chk("t6_resp", {x_rsp_v, x_rsp_id, x_rsp_z, x_rsp_res}, {1'b1, 1'b0, 1'b0, 32'hF800_0000});
    @(posedge clk); #1;
    chk("t6_done", {x_rsp_v, x_busy}, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
